normalize_shift_counter: RTL

Post-addition normalizer for the FP adder datapath. It is the left-shift counterpart of the alignment down-counter:
- takes the raw mantissa sum, carry bit included, plus the provisional exponent;
- shifts left one bit per clock until the hidden bit is set, counting shifts and decrementing the exponent;
- on carry-out, does a single right shift with exponent increment instead.
Results are held stable for the rounding stage.

---
 rtl/normalize_shift_counter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/normalize_shift_counter.sv
// Post-add normalizer: shifts the mantissa sum left until the hidden bit is set,
// or right once on carry-out, adjusting the exponent to match.
module normalize_shift_counter #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8,
  parameter int CNT_W  = 5
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Load,
  input  logic [MANT_W:0]   mant_in,
  input  logic [EXP_W-1:0]  exp_in,
  output logic              busy,
  output logic              done,
  output logic [MANT_W-1:0] mant_out,
  output logic [EXP_W-1:0]  exp_out,
  output logic [CNT_W-1:0]  shift_count,
  output logic              sticky_out,
  output logic              zero,
  output logic              overflow,
  output logic              underflow
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CARRY,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [MANT_W:0]   mant_q, mant_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sticky_q, sticky_d;
  logic              zero_q, zero_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              accept;
  logic [EXP_W-1:0]  exp_inc;

  assign accept  = Load && (state_q == S_IDLE || state_q == S_DONE);
  assign exp_inc = exp_q + EXP_W'(1);

  always_comb begin
    state_d  = state_q;
    mant_d   = mant_q;
    exp_d    = exp_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (accept) begin
      mant_d   = mant_in;
      exp_d    = exp_in;
      cnt_d    = '0;
      sticky_d = 1'b0;
      zero_d   = 1'b0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
      if (mant_in == '0) begin
        state_d = S_DONE;
        zero_d  = 1'b1;
        exp_d   = '0;
      end else if (mant_in[MANT_W]) begin
        state_d = S_CARRY;
      end else begin
        state_d = S_SHIFT;
      end
    end else begin
      case (state_q)
        S_CARRY: begin
          mant_d   = {1'b0, mant_q[MANT_W:1]};
          sticky_d = mant_q[0];
          exp_d    = exp_inc;
          ovf_d    = &exp_inc;
          state_d  = S_DONE;
        end
        S_SHIFT: begin
          // hidden bit wins over the exponent floor check
          if (mant_q[MANT_W-1]) begin
            state_d = S_DONE;
          end else if (exp_q <= EXP_W'(1)) begin
            unf_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            mant_d = {mant_q[MANT_W-1:0], 1'b0};
            exp_d  = exp_q - EXP_W'(1);
            cnt_d  = cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= S_IDLE;
      mant_q   <= '0;
      exp_q    <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mant_q   <= mant_d;
      exp_q    <= exp_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign busy        = (state_q == S_CARRY) || (state_q == S_SHIFT);
  assign done        = (state_q == S_DONE);
  assign mant_out    = mant_q[MANT_W-1:0];
  assign exp_out     = exp_q;
  assign shift_count = cnt_q;
  assign sticky_out  = sticky_q;
  assign zero        = zero_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;

endmodule
